stream_mux_rr: RTL and testbench

- Parametrised N-to-1 stream selector; successor to the fixed-width combinational 2/3/4-to-1 selectors.
- Merges N valid/ready input channels of WIDTH bits into one registered output channel.
- Two modes: fixed select (legacy mux behaviour, now registered and flow-controlled) and round-robin arbitration.
- Sits between the 128-bit datapath stages, e.g. choosing among round-key/state sources, and adds backpressure.

---
 rtl/stream_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/stream_mux_rr.sv | 93 +++++++++
 tb/tb_stream_mux_rr.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream selector family: mode encodings and
// modulo-N pointer arithmetic used by the round-robin logic.
package stream_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Advance a channel pointer by one, wrapping from n-1 back to 0.
    function automatic int ptr_inc(input int p, input int n);
        if (p + 1 >= n)
            return 0;
        else
            return p + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request arbiter: picks the first asserted request at or above
// ptr, wrapping modulo N, and reports it as a one-hot grant plus an index.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx,
    output logic            any
);

    int start;
    int c;

    // Scan the N candidates starting at the pointer and keep the first hit.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        start = (int'(ptr) < N) ? int'(ptr) : 0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = start + k;
            if (c >= N)
                c = c - N;
            if (!any && req[c]) begin
                any      = 1'b1;
                idx      = SELW'(c);
                grant[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream selector with a single registered output stage.
// Mode 0 forwards a fixed channel; mode 1 arbitrates round-robin.
module stream_mux_rr
    import stream_pkg::*;
#(
    parameter  int WIDTH = 128,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      fixed_sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
);

    logic [SELW-1:0] rr_ptr;
    logic [N-1:0]    rr_grant;
    logic [SELW-1:0] rr_idx;
    logic            rr_any;

    logic [N-1:0]    fixed_grant;
    logic [N-1:0]    gnt_onehot;
    logic [SELW-1:0] gnt_idx;
    logic            gnt_any;
    logic            can_load;
    logic            transfer;
    logic [WIDTH-1:0] gnt_data;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    assign can_load = !out_valid || out_ready;

    // Fixed-select grant: only a valid, in-range channel can be chosen.
    always_comb begin
        fixed_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (fixed_sel == SELW'(i) && in_valid[i])
                fixed_grant[i] = 1'b1;
        end
    end

    // Choose the active grant source and raise ready only when the stage can load.
    always_comb begin
        if (mode == MODE_RR) begin
            gnt_onehot = rr_grant;
            gnt_idx    = rr_idx;
            gnt_any    = rr_any;
        end else begin
            gnt_onehot = fixed_grant;
            gnt_idx    = fixed_sel;
            gnt_any    = |fixed_grant;
        end
        in_ready = (!rst && can_load && gnt_any) ? gnt_onehot : '0;
    end

    assign transfer = |(in_ready & in_valid);
    assign gnt_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];

    // Output register: load on handshake, drain when consumed, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_sel   <= gnt_idx;
            if (mode == MODE_RR)
                rr_ptr <= SELW'(ptr_inc(int'(gnt_idx), N));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr against a behavioural model that
// tracks the output word, its source and the round-robin pointer.
module tb_stream_mux_rr;

    localparam int WIDTH = 128;
    localparam int N     = 4;
    localparam int SELW  = $clog2(N);

    logic                clk = 1'b0;
    logic                rst;
    logic                mode;
    logic [SELW-1:0]     fixed_sel;
    logic [N*WIDTH-1:0]  in_data;
    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_ready;
    logic [WIDTH-1:0]    out_data;
    logic                out_valid;
    logic                out_ready;
    logic [SELW-1:0]     out_sel;

    logic [WIDTH-1:0]    ch_data [N];

    int errors = 0;
    int checks = 0;

    // Model state
    logic                m_valid;
    logic [WIDTH-1:0]    m_data;
    int                  m_sel;
    int                  m_ptr;
    logic [N-1:0]        exp_ready;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++)
            in_data[i*WIDTH +: WIDTH] = ch_data[i];
    end

    stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .fixed_sel (fixed_sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    // Which channel the rules say should win this cycle, or -1 for none.
    function automatic int model_grant();
        if (mode == 1'b0) begin
            if (int'(fixed_sel) < N && in_valid[fixed_sel])
                return int'(fixed_sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr + k) % N])
                return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Wait for the inputs to settle and work out the expected ready vector.
    task automatic settle();
        int g;
        @(negedge clk);
        g = model_grant();
        exp_ready = '0;
        if (!rst && (!m_valid || out_ready) && g >= 0)
            exp_ready[g] = 1'b1;
    endtask

    // Apply the clock edge to the model, then to the DUT.
    task automatic advance();
        int g;
        g = model_grant();
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 0;
            m_ptr   = 0;
        end else if ((!m_valid || out_ready) && g >= 0) begin
            m_valid = 1'b1;
            m_data  = ch_data[g];
            m_sel   = g;
            if (mode == 1'b1)
                m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++)
            ch_data[i] = rand_word();
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; fixed_sel = '0; in_valid = '1; out_ready = 1'b1;
        randomize_data();
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if (in_ready !== '0) begin
                errors++;
                $display("[TB] FAIL reset_ready cycle %0d: got %b want 0", c, in_ready);
            end
            advance();
            checks++;
            if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0) begin
                errors++;
                $display("[TB] FAIL reset_out cycle %0d: got v=%b d=%h s=%0d want 0/0/0", c, out_valid, out_data, out_sel);
            end
        end
        rst = 1'b0;
        settle();
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got %b want 0001", in_ready);
        end
        advance();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== ch_data[0]) begin
            errors++;
            $display("[TB] FAIL reset_first_word: got v=%b s=%0d want v=1 s=0", out_valid, out_sel);
        end
    endtask

    task automatic test_fixed();
        mode = 1'b0; fixed_sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < N; i++)
            ch_data[i] = WIDTH'(i * 'h11);
        for (int c = 0; c < 4; c++) begin
            settle();
            checks++;
            if (in_ready !== 4'b0100) begin
                errors++;
                $display("[TB] FAIL fixed_ready cycle %0d: got %b want 0100", c, in_ready);
            end
            advance();
            checks++;
            if (out_valid !== 1'b1 || out_data !== WIDTH'('h22) || out_sel !== 2'd2) begin
                errors++;
                $display("[TB] FAIL fixed_out cycle %0d: got v=%b d=%h s=%0d want 1/22/2", c, out_valid, out_data, out_sel);
            end
        end
    endtask

    task automatic restart();
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        restart();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            randomize_data();
            settle();
            advance();
            checks++;
            if (out_valid !== 1'b1 || int'(out_sel) != (c % N) || out_data !== m_data) begin
                errors++;
                $display("[TB] FAIL rr_seq cycle %0d: got v=%b s=%0d want v=1 s=%0d", c, out_valid, out_sel, c % N);
            end
        end
    endtask

    task automatic test_sparse_wrap();
        int seq [3] = '{1, 2, 1};
        restart();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            advance();
        end
        in_valid = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            randomize_data();
            settle();
            advance();
            checks++;
            if (out_valid !== 1'b1 || int'(out_sel) != seq[c] || out_data !== ch_data[seq[c]]) begin
                errors++;
                $display("[TB] FAIL sparse_wrap step %0d: got s=%0d want s=%0d", c, out_sel, seq[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] held_data;
        logic [SELW-1:0]  held_sel;
        restart();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        randomize_data();
        settle();
        advance();
        held_data = m_data;
        held_sel  = SELW'(m_sel);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            randomize_data();
            settle();
            checks++;
            if (in_ready !== '0) begin
                errors++;
                $display("[TB] FAIL stall_ready cycle %0d: got %b want 0", c, in_ready);
            end
            advance();
            checks++;
            if (out_valid !== 1'b1 || out_data !== held_data || out_sel !== held_sel) begin
                errors++;
                $display("[TB] FAIL stall_hold cycle %0d: got v=%b s=%0d want v=1 s=%0d", c, out_valid, out_sel, held_sel);
            end
        end
        out_ready = 1'b1;
        settle();
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL stall_release_ready: got %b want 0010", in_ready);
        end
        advance();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== ch_data[1]) begin
            errors++;
            $display("[TB] FAIL stall_reload: got v=%b s=%0d want v=1 s=1", out_valid, out_sel);
        end
    endtask

    task automatic test_reset_mid();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
        randomize_data();
        settle();
        advance();
        rst = 1'b1;
        settle();
        checks++;
        if (in_ready !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_ready: got %b want 0", in_ready);
        end
        advance();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_valid: got %b want 0", out_valid);
        end
        out_ready = 1'b1;
        settle();
        advance();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0) begin
            errors++;
            $display("[TB] FAIL midreset_grant: got v=%b s=%0d want v=1 s=0", out_valid, out_sel);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rst       = ($urandom_range(0, 39) == 0);
            mode      = ($urandom_range(0, 3) != 0);
            fixed_sel = SELW'($urandom_range(0, N - 1));
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            randomize_data();
            settle();
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL random_ready cycle %0d: got %b want %b", c, in_ready, exp_ready);
            end
            advance();
            checks++;
            if (out_valid !== m_valid || out_data !== m_data || int'(out_sel) != m_sel) begin
                errors++;
                $display("[TB] FAIL random_out cycle %0d: got v=%b s=%0d d=%h want v=%b s=%0d d=%h",
                         c, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
            end
        end
        rst = 1'b0;
    endtask

    // Run every scenario in order and report the totals.
    initial begin
        m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0; exp_ready = '0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_sparse_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
